locked_alu_pipe: RTL and testbench
==================================

Name: locked_alu_pipe

Overview:
- Parametrised, pipelined successor of the team's key-locked add/sub + constant-multiply datapath.
- Adds generic WIDTH, a valid/ready handshake, a 2-stage pipeline, and a key-locked multiply-accumulate mode with a persistent accumulator.
- Correct function only when locking_key carries the correct (all-zero) working-key field.
- Sits between an operand source and a result consumer in obfuscated HLS-style designs.

Parameters:
- WIDTH, 8, operand width of in1/in2/in3 and out1.
- MUL_CONST, 8'h67 (WIDTH bits), plaintext multiplier constant before key XOR.
- LOCK_W, 255, width of locking_key; must be >= WIDTH+4.

Ports:
- ap_clk  in  1  clock, all state rising-edge.
- ap_rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept beat.
- in1, in2, in3  in  WIDTH  operands.
- sel  in  1  0 = add, 1 = subtract (pre-key).
- mac  in  1  0 = out2 is product, 1 = out2 is accumulate (pre-key).
- acc_clr  in  1  clear accumulator on the accepted beat.
- out_valid  out  1  result beat valid.
- out_ready  in  1  consumer accepts result.
- out1  out  WIDTH  add/sub result.
- out2  out  2*WIDTH  product or accumulator value.
- ap_idle  out  1  pipeline-empty flag (key-locked).
- locking_key  in  LOCK_W  static lock key.

Behaviour:
- Working key field: wk = locking_key[WIDTH+3:0]. Layout:
  - wk[0]: idle polarity.
  - wk[1]: sel flip.
  - wk[2]: mac flip.
  - wk[WIDTH+2:3]: constant mask.
  - wk[WIDTH+3]: acc_clr flip.
  - All other locking_key bits are ignored.
- Effective controls:
  - esel = sel ^ wk[1]
  - emac = mac ^ wk[2]
  - eclr = acc_clr ^ wk[WIDTH+3]
  - K = MUL_CONST ^ wk[WIDTH+2:3]
- Stage 1 (S1) registers in1, in2, in3, esel, emac, eclr and sets s1_valid.
- Stage 2 (S2) registers the results and sets s2_valid (= out_valid). Latency from accepted input to out_valid is 2 cycles; throughput is 1 beat/cycle when out_ready=1.
- Advance rules:
  - s2_load = s1_valid && (!s2_valid || out_ready)
  - in_ready = !s1_valid || s2_load (combinational, no dependence on in_valid)
  - s1_load = in_valid && in_ready
  - s2_valid clears when out_ready is high and s2_load is low.
- Results:
  - out1 = esel ? in1-in2 : in1+in2, truncated mod 2^WIDTH.
  - P = in3*K, full 2*WIDTH bits.
  - out2 = P when emac=0. When emac=1: acc_next = (eclr ? 0 : acc) + P, mod 2^(2*WIDTH); out2 = acc_next.
- Accumulator rules:
  - acc updates only on s2_load with emac=1.
  - eclr with emac=0 sets acc to 0 on s2_load; out2 is still P.
  - acc holds while the output is stalled.
- Outputs out1/out2 hold stable while out_valid && !out_ready.
- ap_idle = (!s1_valid && !s2_valid) ^ wk[0], combinational from registered valids.
- Reset (any time, including mid-operation) clears immediately:
  - s1_valid, s2_valid, acc, out1, out2, and all stage registers go to 0.
  - in-flight beats are discarded.
  - in_ready=1 and ap_idle = 1 ^ wk[0] while reset is asserted and after it is released.
- Simultaneous S1 load and S2 load in the same cycle are legal; order is preserved and no beat is dropped or duplicated.

Decomposition:
- Package locked_alu_pkg holds:
  - key-field offset constants (KEY_IDLE=0, KEY_SEL=1, KEY_MAC=2, KEY_CONST=3).
  - localparam function for KEY_CLR = WIDTH+3.
  - typedef of the S1 payload struct.
- Sub-module locked_alu_key_decode: pure combinational; takes locking_key, sel, mac, acc_clr and produces esel, emac, eclr, K, idle_pol.

Test Plan (WIDTH=8, locking_key=0 unless stated):
- Add wrap: in1=200, in2=100, sel=0, in3=3, mac=0 -> 2 cycles later out1=44, out2=309, out_valid=1.
- Sub wrap: in1=5, in2=10, sel=1 -> out1=251.
- MAC chain: acc_clr=1, mac=1, in3=1; then mac=1, in3=2 -> out2=103 then 309. A following beat with acc_clr=1, in3=1 -> out2=103.
- Wrong key:
  - locking_key[1]=1, sel=0, in1=9, in2=4 -> out1=5.
  - locking_key[10:3]=8'h01, in3=2 -> out2=204.
  - locking_key[0]=1 in reset -> ap_idle=0.
- Backpressure: out_ready=0 while 3 beats are offered -> 2 accepted, in_ready=0 on the third. Raise out_ready -> all 3 emerge in order with no loss or duplication; acc advances once per beat.
- Reset mid-stream: assert ap_rst_n=0 with both stages full -> out_valid=0, acc=0 immediately. The first beat after release produces a result 2 cycles after acceptance.

Source files
------------

// File: rtl/locked_alu_pipe_pkg.sv
// Shared constants and types for the key-locked ALU pipeline: working-key
// field offsets and the stage-1 control payload.
package locked_alu_pkg;

  localparam int KEY_IDLE  = 0;
  localparam int KEY_SEL   = 1;
  localparam int KEY_MAC   = 2;
  localparam int KEY_CONST = 3;

  // The acc_clr flip bit sits just above the WIDTH-bit constant mask.
  function automatic int key_clr(input int width);
    return width + 3;
  endfunction

  typedef struct packed {
    logic esel;
    logic emac;
    logic eclr;
  } s1_ctrl_t;

endpackage

// File: rtl/locked_alu_pipe_if.sv
// Operand/result handshake bundle between the operand source, the
// locked ALU pipeline and the result consumer.
interface locked_alu_pipe_if #(
  parameter int WIDTH = 8
);
  // A beat transfers on a rising clock edge where valid && ready are both high.
  // Once raised, valid and its payload are held until that edge; ready may be
  // raised or dropped at any time and never depends on the same side's valid.
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in1;
  logic [WIDTH-1:0]   in2;
  logic [WIDTH-1:0]   in3;
  logic               sel;
  logic               mac;
  logic               acc_clr;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out1;
  logic [2*WIDTH-1:0] out2;

  modport master (
    output in_valid, in1, in2, in3, sel, mac, acc_clr, out_ready,
    input  in_ready, out_valid, out1, out2
  );

  modport slave (
    input  in_valid, in1, in2, in3, sel, mac, acc_clr, out_ready,
    output in_ready, out_valid, out1, out2
  );
endinterface

// File: rtl/locked_alu_pipe_key_decode.sv
// Applies the working-key field of locking_key to the raw controls and the
// multiplier constant. Purely combinational.
module locked_alu_key_decode
  import locked_alu_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] MUL_CONST = WIDTH'(8'h67),
  parameter int               LOCK_W    = 255
) (
  input  logic [LOCK_W-1:0] locking_key,
  input  logic              sel,
  input  logic              mac,
  input  logic              acc_clr,
  output logic              esel,
  output logic              emac,
  output logic              eclr,
  output logic [WIDTH-1:0]  k_const,
  output logic              idle_pol
);
  localparam int KEY_CLR = key_clr(WIDTH);

  assign esel     = sel ^ locking_key[KEY_SEL];
  assign emac     = mac ^ locking_key[KEY_MAC];
  assign eclr     = acc_clr ^ locking_key[KEY_CLR];
  assign k_const  = MUL_CONST ^ locking_key[KEY_CONST +: WIDTH];
  assign idle_pol = locking_key[KEY_IDLE];

  // Bits above the working-key field carry no function.
  generate
    if (LOCK_W > WIDTH + 4) begin : g_spare
      logic unused_key_bits;
      assign unused_key_bits = ^locking_key[LOCK_W-1:WIDTH+4];
    end
  endgenerate
endmodule

// File: rtl/locked_alu_pipe.sv
// Two-stage key-locked add/sub + constant-multiply / multiply-accumulate
// pipeline with valid/ready flow control on both sides.
module locked_alu_pipe
  import locked_alu_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] MUL_CONST = WIDTH'(8'h67),
  parameter int               LOCK_W    = 255
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  locked_alu_pipe_if.slave  bus,
  input  logic [LOCK_W-1:0] locking_key,
  output logic              ap_idle
);
  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    s1_ctrl_t         ctrl;
  } s1_payload_t;

  logic               esel, emac, eclr, idle_pol;
  logic [WIDTH-1:0]   k_const;
  s1_payload_t        s1_d, s1_q;
  logic               s1_valid, s2_valid;
  logic               s1_load, s2_load;
  logic [WIDTH-1:0]   out1_q, sum;
  logic [2*WIDTH-1:0] out2_q, acc_q, prod, acc_base, acc_next;

  locked_alu_key_decode #(
    .WIDTH     (WIDTH),
    .MUL_CONST (MUL_CONST),
    .LOCK_W    (LOCK_W)
  ) u_key_decode (
    .locking_key (locking_key),
    .sel         (bus.sel),
    .mac         (bus.mac),
    .acc_clr     (bus.acc_clr),
    .esel        (esel),
    .emac        (emac),
    .eclr        (eclr),
    .k_const     (k_const),
    .idle_pol    (idle_pol)
  );

  assign s2_load      = s1_valid && (!s2_valid || bus.out_ready);
  assign bus.in_ready = !s1_valid || s2_load;
  assign s1_load      = bus.in_valid && bus.in_ready;

  always_comb begin
    s1_d.a         = bus.in1;
    s1_d.b         = bus.in2;
    s1_d.c         = bus.in3;
    s1_d.ctrl.esel = esel;
    s1_d.ctrl.emac = emac;
    s1_d.ctrl.eclr = eclr;
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (s1_load) begin
      s1_valid <= 1'b1;
      s1_q     <= s1_d;
    end else if (s2_load) begin
      s1_valid <= 1'b0;
    end
  end

  // Stage-2 arithmetic works from the registered stage-1 payload.
  always_comb begin
    sum      = s1_q.ctrl.esel ? (s1_q.a - s1_q.b) : (s1_q.a + s1_q.b);
    prod     = {{WIDTH{1'b0}}, s1_q.c} * {{WIDTH{1'b0}}, k_const};
    acc_base = s1_q.ctrl.eclr ? '0 : acc_q;
    acc_next = acc_base + prod;
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      s2_valid <= 1'b0;
      out1_q   <= '0;
      out2_q   <= '0;
      acc_q    <= '0;
    end else if (s2_load) begin
      s2_valid <= 1'b1;
      out1_q   <= sum;
      out2_q   <= s1_q.ctrl.emac ? acc_next : prod;
      if (s1_q.ctrl.emac) begin
        acc_q <= acc_next;
      end else if (s1_q.ctrl.eclr) begin
        acc_q <= '0;
      end
    end else if (bus.out_ready) begin
      s2_valid <= 1'b0;
    end
  end

  assign bus.out_valid = s2_valid;
  assign bus.out1      = out1_q;
  assign bus.out2      = out2_q;
  assign ap_idle       = (!s1_valid && !s2_valid) ^ idle_pol;
endmodule

// File: tb/tb_locked_alu_pipe.sv
// Directed scoreboard bench for locked_alu_pipe: expected {out1,out2} pairs
// are queued on acceptance and popped by an independent output monitor.
module tb_locked_alu_pipe;
  localparam int W  = 8;
  localparam int LW = 255;

  logic          ap_clk   = 1'b0;
  logic          ap_rst_n = 1'b1;
  logic [LW-1:0] locking_key = '0;
  logic          ap_idle;

  locked_alu_pipe_if #(.WIDTH(W)) bus ();

  locked_alu_pipe #(
    .WIDTH     (W),
    .MUL_CONST (8'h67),
    .LOCK_W    (LW)
  ) dut (
    .ap_clk      (ap_clk),
    .ap_rst_n    (ap_rst_n),
    .bus         (bus),
    .locking_key (locking_key),
    .ap_idle     (ap_idle)
  );

  // ---------------- clock / reset ----------------
  always #5 ap_clk = ~ap_clk;

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_err    = 0;
  logic [3*W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(negedge ap_clk);
      if (ap_rst_n && bus.out_valid && bus.out_ready) begin : pop_one
        logic [3*W-1:0] e;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_beat: got out1=%0d out2=%0d, expected no beat", bus.out1, bus.out2);
        end else begin
          e = exp_q.pop_front();
          check("out1", 32'(bus.out1), 32'(e[3*W-1:2*W]));
          check("out2", 32'(bus.out2), 32'(e[2*W-1:0]));
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic idle_inputs();
    bus.in_valid = 1'b0;
    bus.in1 = '0; bus.in2 = '0; bus.in3 = '0;
    bus.sel = 1'b0; bus.mac = 1'b0; bus.acc_clr = 1'b0;
  endtask

  task automatic offer(input logic [W-1:0] i1, input logic [W-1:0] i2, input logic [W-1:0] i3,
                       input logic s, input logic m, input logic c);
    bus.in1 = i1; bus.in2 = i2; bus.in3 = i3;
    bus.sel = s; bus.mac = m; bus.acc_clr = c;
    bus.in_valid = 1'b1;
  endtask

  task automatic wait_accept(input logic [W-1:0] e1, input logic [2*W-1:0] e2);
    bit ok = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge ap_clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      n_err++;
      $display("FAIL accept_timeout: got in_ready=0 for 50 cycles, expected 1");
      bus.in_valid = 1'b0;
    end else begin
      @(posedge ap_clk);
      exp_q.push_back({e1, e2});
      #1 bus.in_valid = 1'b0;
    end
  endtask

  task automatic send(input logic [W-1:0] i1, input logic [W-1:0] i2, input logic [W-1:0] i3,
                      input logic s, input logic m, input logic c,
                      input logic [W-1:0] e1, input logic [2*W-1:0] e2);
    offer(i1, i2, i3, s, m, c);
    wait_accept(e1, e2);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge ap_clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_err++;
      $display("FAIL drain_timeout: got %0d beats outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge ap_clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle_inputs();
    bus.out_ready = 1'b1;
    #1 ap_rst_n = 1'b0;
    #1;
    check("reset_in_ready", 32'(bus.in_ready), 1);
    check("reset_out_valid", 32'(bus.out_valid), 0);
    check("reset_ap_idle", 32'(ap_idle), 1);
    repeat (2) @(posedge ap_clk);
    #1 ap_rst_n = 1'b1;
    check("release_in_ready", 32'(bus.in_ready), 1);

    // Add with wrap; out_valid appears on the second edge after acceptance
    send(8'd200, 8'd100, 8'd3, 1'b0, 1'b0, 1'b0, 8'd44, 16'd309);
    @(negedge ap_clk);
    check("lat_cycle1_out_valid", 32'(bus.out_valid), 0);
    check("busy_ap_idle", 32'(ap_idle), 0);
    @(negedge ap_clk);
    check("lat_cycle2_out_valid", 32'(bus.out_valid), 1);
    drain();

    // Sub with wrap
    send(8'd5, 8'd10, 8'd0, 1'b1, 1'b0, 1'b0, 8'd251, 16'd0);
    // MAC chain, back to back
    send(8'd0, 8'd0, 8'd1, 1'b0, 1'b1, 1'b1, 8'd0, 16'd103);
    send(8'd0, 8'd0, 8'd2, 1'b0, 1'b1, 1'b0, 8'd0, 16'd309);
    send(8'd0, 8'd0, 8'd1, 1'b0, 1'b1, 1'b1, 8'd0, 16'd103);
    // Clear with product mode: acc zeroed, out2 is still the product
    send(8'd0, 8'd0, 8'd4, 1'b0, 1'b0, 1'b1, 8'd0, 16'd412);
    send(8'd0, 8'd0, 8'd1, 1'b0, 1'b1, 1'b0, 8'd0, 16'd103);
    // Accumulator wraps mod 2^16
    send(8'd255, 8'd1, 8'd255, 1'b0, 1'b1, 1'b1, 8'd0, 16'd26265);
    send(8'd0, 8'd0, 8'd255, 1'b0, 1'b1, 1'b0, 8'd0, 16'd52530);
    send(8'd0, 8'd0, 8'd255, 1'b0, 1'b1, 1'b0, 8'd0, 16'd13259);
    drain();

    // Wrong-key behaviour
    locking_key[1] = 1'b1;
    send(8'd9, 8'd4, 8'd0, 1'b0, 1'b0, 1'b0, 8'd5, 16'd0);
    drain();
    locking_key = '0;
    locking_key[10:3] = 8'h01;
    send(8'd0, 8'd0, 8'd2, 1'b0, 1'b0, 1'b0, 8'd0, 16'd204);
    drain();
    locking_key = '0;
    locking_key[11] = 1'b1;
    send(8'd0, 8'd0, 8'd1, 1'b0, 1'b1, 1'b0, 8'd0, 16'd103);
    drain();
    locking_key = '0;
    locking_key[2] = 1'b1;
    send(8'd0, 8'd0, 8'd1, 1'b0, 1'b0, 1'b0, 8'd0, 16'd206);
    drain();
    locking_key = '0;

    // Idle polarity under reset
    locking_key[0] = 1'b1;
    ap_rst_n = 1'b0;
    #1;
    check("key_idle_ap_idle", 32'(ap_idle), 0);
    check("key_idle_in_ready", 32'(bus.in_ready), 1);
    locking_key = '0;
    #1;
    check("reset_ap_idle_again", 32'(ap_idle), 1);
    @(posedge ap_clk);
    #1 ap_rst_n = 1'b1;

    // Backpressure: two beats fill the pipe, the third waits
    bus.out_ready = 1'b0;
    send(8'd1, 8'd1, 8'd1, 1'b0, 1'b1, 1'b1, 8'd2, 16'd103);
    send(8'd3, 8'd1, 8'd2, 1'b1, 1'b1, 1'b0, 8'd2, 16'd309);
    offer(8'd7, 8'd8, 8'd3, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge ap_clk);
      check("bp_in_ready", 32'(bus.in_ready), 0);
      check("bp_out_valid", 32'(bus.out_valid), 1);
      check("bp_out2_hold", 32'(bus.out2), 103);
      check("bp_out1_hold", 32'(bus.out1), 2);
    end
    @(posedge ap_clk);
    #1 bus.out_ready = 1'b1;
    wait_accept(8'd15, 16'd618);
    drain();

    // Reset with both stages full
    bus.out_ready = 1'b0;
    send(8'd0, 8'd0, 8'd1, 1'b0, 1'b1, 1'b1, 8'd0, 16'd103);
    send(8'd0, 8'd0, 8'd2, 1'b0, 1'b1, 1'b0, 8'd0, 16'd309);
    @(negedge ap_clk);
    check("full_out_valid", 32'(bus.out_valid), 1);
    check("full_in_ready", 32'(bus.in_ready), 0);
    #2 ap_rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("midrst_out_valid", 32'(bus.out_valid), 0);
    check("midrst_in_ready", 32'(bus.in_ready), 1);
    check("midrst_ap_idle", 32'(ap_idle), 1);
    check("midrst_out2", 32'(bus.out2), 0);
    @(posedge ap_clk);
    #1 ap_rst_n = 1'b1;
    bus.out_ready = 1'b1;
    // acc was cleared by reset, so accumulating 1*K yields K alone
    send(8'd0, 8'd0, 8'd1, 1'b0, 1'b1, 1'b0, 8'd0, 16'd103);
    @(negedge ap_clk);
    check("post_rst_lat1", 32'(bus.out_valid), 0);
    @(negedge ap_clk);
    check("post_rst_lat2", 32'(bus.out_valid), 1);
    drain();
    check("end_out_valid", 32'(bus.out_valid), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by %0t, expected finish", $time);
    $fatal(1, "watchdog expired");
  end
endmodule
